control_sequencer: RTL and testbench

- Hardwired control unit that sits directly upstream of the datapath and drives its bus, register and ALU control strobes.
- Steps a Moore FSM through a shared fetch (T0-T2), then an opcode-specific execute sequence (T3-T6), using the instruction word returned from the datapath IR.
- Replaces bench-driven control sequencing with synthesizable control.
- Covers the register-register ALU, mul/div, neg/not, mfhi/mflo, nop and halt subset.

---
 rtl/control_sequencer.sv | 170 +++++++++++++++++
 tb/tb_control_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: shared three-state fetch, then an opcode-specific
// execute sequence driving the datapath bus, register and ALU strobes.
module control_sequencer #(
    parameter int OPW           = 5,
    parameter int RESET_PC_HOLD = 1
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           stop,
    output logic           run,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           Zin,
    output logic           PCin,
    output logic           Zlowout,
    output logic           ZHighout,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           HIin,
    output logic           LOin,
    output logic           HIout,
    output logic           LOout,
    output logic [OPW-1:0] alu_op
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01001);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);
    localparam logic [1:0]     HOLD    = 2'(RESET_PC_HOLD);

    state_t         state, state_next;
    logic [1:0]     hold_cnt, hold_next;
    logic [OPW-1:0] opcode;
    logic           is_alu3, is_muldiv, is_negnot, is_mfhi, is_mflo, is_nop, is_halt, valid;
    state_t         boundary;
    logic           unused_ir;

    assign unused_ir = ^ir[31-OPW:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_RESET;
            hold_cnt <= 2'd0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
        end
    end

    // The datapath IR is already holding the fetched word when T2 ends.
    always_ff @(posedge clock) begin
        if (state == S_T2) opcode <= ir[31 -: OPW];
    end

    always_comb begin
        is_alu3   = 1'b0;
        is_muldiv = 1'b0;
        is_negnot = 1'b0;
        is_mfhi   = 1'b0;
        is_mflo   = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: is_alu3   = 1'b1;
            OP_DIV, OP_MUL:                is_muldiv = 1'b1;
            OP_NEG, OP_NOT:                is_negnot = 1'b1;
            OP_MFHI:                       is_mfhi   = 1'b1;
            OP_MFLO:                       is_mflo   = 1'b1;
            OP_NOP:                        is_nop    = 1'b1;
            OP_HALT:                       is_halt   = 1'b1;
            default:                       ;
        endcase
        valid = is_alu3 | is_muldiv | is_negnot | is_mfhi | is_mflo | is_nop | is_halt;
    end

    // stop is only honoured on the edge that would start a new fetch.
    assign boundary = stop ? S_HALT : S_T0;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            S_RESET: begin
                if (hold_cnt == HOLD) state_next = boundary;
                else                  hold_next  = hold_cnt + 2'd1;
            end
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                if (is_alu3 || is_muldiv || is_negnot) state_next = S_T4;
                else if (is_halt)                      state_next = S_HALT;
                else                                   state_next = boundary;
            end
            S_T4:   state_next = (is_alu3 || is_muldiv) ? S_T5 : boundary;
            S_T5:   state_next = is_muldiv ? S_T6 : boundary;
            S_T6:   state_next = boundary;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    always_comb begin
        run = 1'b0;  PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; PCin = 1'b0;
        Zlowout = 1'b0; ZHighout = 1'b0; Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        IRin = 1'b0; Yin = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0;
        Rout = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        alu_op = '0;
        case (state)
            S_T0: begin run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin run = 1'b1; MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                run    = 1'b1;
                alu_op = valid ? opcode : '0;
                if (is_alu3)   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                if (is_muldiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                if (is_negnot) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                if (is_mfhi)   begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                if (is_mflo)   begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T4: begin
                run    = 1'b1;
                alu_op = opcode;
                if (is_alu3)   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                if (is_muldiv) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                if (is_negnot) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            S_T5: begin
                run     = 1'b1;
                alu_op  = opcode;
                Zlowout = 1'b1;
                if (is_alu3)   begin Gra = 1'b1; Rin = 1'b1; end
                if (is_muldiv) LOin = 1'b1;
            end
            S_T6: begin run = 1'b1; alu_op = opcode; ZHighout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instructions cycle by cycle and
// compares every strobe, run and alu_op against hand-derived expectations.
module tb_control_sequencer;

    logic        clock, clear, stop;
    logic [31:0] ir;
    logic        run, PCout, MARin, IncPC, Zin, PCin, Zlowout, ZHighout, Read, MDRin, MDRout;
    logic        IRin, Yin, Gra, Grb, Grc, Rin, Rout, HIin, LOin, HIout, LOout;
    logic [4:0]  alu_op;
    logic [20:0] strobes;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [20:0] PCOUT  = 21'b1 << 20;
    localparam logic [20:0] MARIN  = 21'b1 << 19;
    localparam logic [20:0] INCPC  = 21'b1 << 18;
    localparam logic [20:0] ZIN    = 21'b1 << 17;
    localparam logic [20:0] PCIN   = 21'b1 << 16;
    localparam logic [20:0] ZLO    = 21'b1 << 15;
    localparam logic [20:0] ZHI    = 21'b1 << 14;
    localparam logic [20:0] READ   = 21'b1 << 13;
    localparam logic [20:0] MDRIN  = 21'b1 << 12;
    localparam logic [20:0] MDROUT = 21'b1 << 11;
    localparam logic [20:0] IRIN   = 21'b1 << 10;
    localparam logic [20:0] YIN    = 21'b1 << 9;
    localparam logic [20:0] GRA    = 21'b1 << 8;
    localparam logic [20:0] GRB    = 21'b1 << 7;
    localparam logic [20:0] GRC    = 21'b1 << 6;
    localparam logic [20:0] RIN    = 21'b1 << 5;
    localparam logic [20:0] ROUT   = 21'b1 << 4;
    localparam logic [20:0] HIIN   = 21'b1 << 3;
    localparam logic [20:0] LOIN   = 21'b1 << 2;
    localparam logic [20:0] HIOUT  = 21'b1 << 1;
    localparam logic [20:0] LOOUT  = 21'b1 << 0;
    localparam logic [20:0] BUS    = PCOUT | ZLO | ZHI | MDROUT | ROUT | HIOUT | LOOUT;

    assign strobes = {PCout, MARin, IncPC, Zin, PCin, Zlowout, ZHighout, Read, MDRin, MDRout,
                      IRin, Yin, Gra, Grb, Grc, Rin, Rout, HIin, LOin, HIout, LOout};

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .stop(stop), .run(run),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .PCin(PCin),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
        .LOout(LOout), .alu_op(alu_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sample on the falling edge.
    task automatic expect_cycle(input string tag, input logic [20:0] strb, input logic exp_run,
                                input logic [4:0] alu, input bit chk_alu);
        @(negedge clock);
        check({tag, ".strobes"}, 32'(strobes), 32'(strb));
        check({tag, ".run"}, 32'(run), 32'(exp_run));
        if (chk_alu) check({tag, ".alu_op"}, 32'(alu_op), 32'(alu));
        check({tag, ".one_bus"}, 32'($countones(strobes & BUS) <= 1), 32'd1);
    endtask

    task automatic fetch(input string tag);
        expect_cycle({tag, ".T0"}, PCOUT | MARIN | INCPC | ZIN, 1'b1, 5'd0, 1'b0);
        expect_cycle({tag, ".T1"}, ZLO | PCIN | READ | MDRIN, 1'b1, 5'd0, 1'b0);
        expect_cycle({tag, ".T2"}, MDROUT | IRIN, 1'b1, 5'd0, 1'b0);
    endtask

    initial begin
        clear = 1'b1;
        stop  = 1'b0;
        ir    = 32'h0;
        repeat (2) @(negedge clock);
        check("reset.strobes", 32'(strobes), 32'd0);
        check("reset.run", 32'(run), 32'd0);
        check("reset.alu_op", 32'(alu_op), 32'd0);

        clear = 1'b0;
        ir    = 32'h59918000;
        expect_cycle("or.hold", 21'd0, 1'b0, 5'd0, 1'b1);
        fetch("or");
        expect_cycle("or.T3", GRB | ROUT | YIN, 1'b1, 5'b01011, 1'b1);
        expect_cycle("or.T4", GRC | ROUT | ZIN, 1'b1, 5'b01011, 1'b1);
        expect_cycle("or.T5", ZLO | GRA | RIN, 1'b1, 5'b01011, 1'b1);

        ir = 32'h80000000;
        fetch("mul");
        expect_cycle("mul.T3", GRA | ROUT | YIN, 1'b1, 5'b10000, 1'b1);
        expect_cycle("mul.T4", GRB | ROUT | ZIN, 1'b1, 5'b10000, 1'b1);
        expect_cycle("mul.T5", ZLO | LOIN, 1'b1, 5'b10000, 1'b1);
        expect_cycle("mul.T6", ZHI | HIIN, 1'b1, 5'b10000, 1'b1);

        ir = 32'h90000000;
        fetch("not");
        expect_cycle("not.T3", GRB | ROUT | ZIN, 1'b1, 5'b10010, 1'b1);
        stop = 1'b1;
        expect_cycle("not.T4", ZLO | GRA | RIN, 1'b1, 5'b10010, 1'b1);
        stop = 1'b0;

        ir = 32'hC8000000;
        fetch("mflo");
        expect_cycle("mflo.T3", LOOUT | GRA | RIN, 1'b1, 5'b11001, 1'b1);

        ir = 32'hF8000000;
        fetch("illegal");
        expect_cycle("illegal.T3", 21'd0, 1'b1, 5'd0, 1'b1);

        ir = 32'h18000000;
        fetch("add_clr");
        expect_cycle("add_clr.T3", GRB | ROUT | YIN, 1'b1, 5'b00011, 1'b1);
        expect_cycle("add_clr.T4", GRC | ROUT | ZIN, 1'b1, 5'b00011, 1'b1);
        #2 clear = 1'b1;
        #1;
        check("clr_async.strobes", 32'(strobes), 32'd0);
        check("clr_async.run", 32'(run), 32'd0);
        check("clr_async.alu_op", 32'(alu_op), 32'd0);
        repeat (2) @(negedge clock);
        check("clr_held.strobes", 32'(strobes), 32'd0);
        clear = 1'b0;
        expect_cycle("add_stop.hold", 21'd0, 1'b0, 5'd0, 1'b1);
        fetch("add_stop");
        expect_cycle("add_stop.T3", GRB | ROUT | YIN, 1'b1, 5'b00011, 1'b1);
        expect_cycle("add_stop.T4", GRC | ROUT | ZIN, 1'b1, 5'b00011, 1'b1);
        stop = 1'b1;
        expect_cycle("add_stop.T5", ZLO | GRA | RIN, 1'b1, 5'b00011, 1'b1);
        expect_cycle("add_stop.halt", 21'd0, 1'b0, 5'd0, 1'b1);
        stop = 1'b0;
        expect_cycle("add_stop.halt2", 21'd0, 1'b0, 5'd0, 1'b1);

        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        ir    = 32'hD8000000;
        expect_cycle("halt.hold", 21'd0, 1'b0, 5'd0, 1'b1);
        fetch("halt");
        expect_cycle("halt.T3", 21'd0, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 11; i++) expect_cycle($sformatf("halt.hold%0d", i), 21'd0, 1'b0, 5'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
